// File: rtl/tlb_map_streamer_if.sv
// AXI4-Stream subset carrying TLB mapping entries from the streamer to the
// TLB controller.
interface tlb_map_streamer_if #(
    parameter int AXI4S_DATA_BITS = 128
);
    logic                       tvalid;
    logic                       tready;
    logic [AXI4S_DATA_BITS-1:0] tdata;
    logic                       tlast;

    modport m (output tvalid, output tdata, output tlast, input tready);
    modport s (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/tlb_map_streamer.sv
// Turns one {vaddr, paddr_host, paddr_card, n_pages} request into n_pages
// consecutive TLB entry beats, then waits for the controller's commit pulse
// (or a timeout) and reports a one-cycle completion.
module tlb_map_streamer #(
    parameter int TLB_ORDER    = 10,
    parameter int PG_BITS      = 12,
    parameter int N_PG_BITS    = 16,
    parameter int TMO_CYCLES   = 65536,
    parameter int VADDR_BITS   = 48,
    parameter int PADDR_BITS   = 44,
    parameter int PID_BITS     = 6,
    parameter int AXI_TLB_BITS = 128
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VADDR_BITS-1:0] req_vaddr,
    input  logic [PADDR_BITS-1:0] req_paddr_host,
    input  logic [PADDR_BITS-1:0] req_paddr_card,
    input  logic [PID_BITS-1:0]   req_pid,
    input  logic [N_PG_BITS-1:0]  req_n_pages,
    input  logic                  req_unmap,
    tlb_map_streamer_if.m         m_axis,
    input  logic                  done_map,
    output logic                  cpl_valid,
    output logic                  cpl_err,
    output logic [31:0]           beat_cnt
);
    localparam int VPN_BITS = VADDR_BITS - PG_BITS;
    localparam int PHY_BITS = PADDR_BITS - PG_BITS;
    localparam int TAG_BITS = VADDR_BITS - TLB_ORDER - PG_BITS;
    localparam int TMO_W    = $clog2(TMO_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_CPL} state_t;

    state_t                    state_q, state_d;
    logic [VPN_BITS-1:0]       vpn_q, vpn_d;
    logic [PHY_BITS-1:0]       ppn_h_q, ppn_h_d, ppn_c_q, ppn_c_d;
    logic [PID_BITS-1:0]       pid_q, pid_d;
    logic                      unmap_q, unmap_d;
    logic [N_PG_BITS-1:0]      remaining_q, remaining_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      req_ready_q, req_ready_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;
    logic [AXI_TLB_BITS-1:0]   tdata_q, tdata_d;
    logic                      cpl_valid_q, cpl_valid_d;
    logic                      cpl_err_q, cpl_err_d;
    logic [31:0]               beat_cnt_q, beat_cnt_d;

    logic [VPN_BITS-1:0]       vpn_inc;
    logic [PHY_BITS-1:0]       ppn_h_inc, ppn_c_inc;

    // Page-offset bits of the addresses carry no information for the TLB.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{req_vaddr[PG_BITS-1:0], req_paddr_host[PG_BITS-1:0],
                                  req_paddr_card[PG_BITS-1:0]};

    assign vpn_inc   = vpn_q + 1'b1;
    assign ppn_h_inc = ppn_h_q + 1'b1;
    assign ppn_c_inc = ppn_c_q + 1'b1;

    // One TLB entry: {ppn_c, ppn_h} in the upper half, {valid, pid, tag, index}
    // in the lower half; removals carry no physical page numbers.
    function automatic logic [AXI_TLB_BITS-1:0] build_beat(
        input logic [VPN_BITS-1:0] vpn,
        input logic [PHY_BITS-1:0] ppn_h,
        input logic [PHY_BITS-1:0] ppn_c,
        input logic [PID_BITS-1:0] pid,
        input logic                unmap
    );
        logic [AXI_TLB_BITS-1:0] beat;
        beat = '0;
        beat[0 +: TLB_ORDER]                     = vpn[TLB_ORDER-1:0];
        beat[TLB_ORDER +: TAG_BITS]              = vpn[TLB_ORDER +: TAG_BITS];
        beat[TLB_ORDER+TAG_BITS +: PID_BITS]     = pid;
        beat[TLB_ORDER+TAG_BITS+PID_BITS]        = ~unmap;
        if (!unmap) begin
            beat[64 +: PHY_BITS]            = ppn_h;
            beat[64+PHY_BITS +: PHY_BITS]   = ppn_c;
        end
        return beat;
    endfunction

    // Next-state and next-output logic for the request/stream/wait/complete FSM.
    always_comb begin
        // NOTE: every _d starts as its _q (pulses start at 0) so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        vpn_d       = vpn_q;
        ppn_h_d     = ppn_h_q;
        ppn_c_d     = ppn_c_q;
        pid_d       = pid_q;
        unmap_d     = unmap_q;
        remaining_d = remaining_q;
        tmo_d       = tmo_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        beat_cnt_d  = beat_cnt_q;
        cpl_valid_d = 1'b0;
        cpl_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    vpn_d       = req_vaddr[PG_BITS +: VPN_BITS];
                    ppn_h_d     = req_paddr_host[PG_BITS +: PHY_BITS];
                    ppn_c_d     = req_paddr_card[PG_BITS +: PHY_BITS];
                    pid_d       = req_pid;
                    unmap_d     = req_unmap;
                    remaining_d = req_n_pages;
                    if (req_n_pages != '0) begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        tlast_d  = (req_n_pages == N_PG_BITS'(1));
                        tdata_d  = build_beat(req_vaddr[PG_BITS +: VPN_BITS],
                                              req_paddr_host[PG_BITS +: PHY_BITS],
                                              req_paddr_card[PG_BITS +: PHY_BITS],
                                              req_pid, req_unmap);
                    end else begin
                        state_d     = ST_CPL;
                        cpl_valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (m_axis.tready) begin
                    vpn_d       = vpn_inc;
                    ppn_h_d     = ppn_h_inc;
                    ppn_c_d     = ppn_c_inc;
                    remaining_d = remaining_q - 1'b1;
                    beat_cnt_d  = beat_cnt_q + 32'd1;
                    if (remaining_q == N_PG_BITS'(1)) begin
                        state_d  = ST_WAIT;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        tmo_d    = '0;
                    end else begin
                        tlast_d = (remaining_q == N_PG_BITS'(2));
                        tdata_d = build_beat(vpn_inc, ppn_h_inc, ppn_c_inc, pid_q, unmap_q);
                    end
                end
            end
            ST_WAIT: begin
                if (done_map) begin
                    state_d     = ST_CPL;
                    cpl_valid_d = 1'b1;
                end else if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
                    state_d     = ST_CPL;
                    cpl_valid_d = 1'b1;
                    cpl_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; synchronous reset aborts any request.
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (areset) begin
            state_q     <= ST_IDLE;
            vpn_q       <= '0;
            ppn_h_q     <= '0;
            ppn_c_q     <= '0;
            pid_q       <= '0;
            unmap_q     <= 1'b0;
            remaining_q <= '0;
            tmo_q       <= '0;
            req_ready_q <= 1'b1;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            cpl_valid_q <= 1'b0;
            cpl_err_q   <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            ppn_h_q     <= ppn_h_d;
            ppn_c_q     <= ppn_c_d;
            pid_q       <= pid_d;
            unmap_q     <= unmap_d;
            remaining_q <= remaining_d;
            tmo_q       <= tmo_d;
            req_ready_q <= req_ready_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_err_q   <= cpl_err_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdata  = tdata_q;
    assign cpl_valid     = cpl_valid_q;
    assign cpl_err       = cpl_err_q;
    assign beat_cnt      = beat_cnt_q;
endmodule

// File: tb/tb_tlb_map_streamer.sv
// Directed bench for tlb_map_streamer: a table of requests with hand-computed
// first/last beats, plus hand-written zero-length, timeout and reset sequences.
module tb_tlb_map_streamer;
    logic         aclk = 1'b0;
    logic         areset;
    logic         req_valid;
    logic         req_ready;
    logic [47:0]  req_vaddr;
    logic [43:0]  req_paddr_host;
    logic [43:0]  req_paddr_card;
    logic [5:0]   req_pid;
    logic [15:0]  req_n_pages;
    logic         req_unmap;
    logic         done_map;
    logic         cpl_valid;
    logic         cpl_err;
    logic [31:0]  beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_beats = 0;

    tlb_map_streamer_if #(.AXI4S_DATA_BITS(128)) m_if ();

    tlb_map_streamer #(.TMO_CYCLES(16)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_vaddr      (req_vaddr),
        .req_paddr_host (req_paddr_host),
        .req_paddr_card (req_paddr_card),
        .req_pid        (req_pid),
        .req_n_pages    (req_n_pages),
        .req_unmap      (req_unmap),
        .m_axis         (m_if),
        .done_map       (done_map),
        .cpl_valid      (cpl_valid),
        .cpl_err        (cpl_err),
        .beat_cnt       (beat_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [47:0]  vaddr;
        logic [43:0]  ph;
        logic [43:0]  pc;
        logic [5:0]   pid;
        logic [15:0]  n;
        logic         unmap;
        logic         stall;
        int           done_delay;
        logic [127:0] exp_first;
        logic [127:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 128'(act), 128'(exp));
    endtask

    // Presents a request at a falling edge; returns at the falling edge after
    // acceptance with the request fields scrambled.
    task automatic send_req(input string name, input logic [47:0] va, input logic [43:0] ph,
                            input logic [43:0] pc, input logic [5:0] pid,
                            input logic [15:0] n, input logic unmap);
        req_vaddr = va; req_paddr_host = ph; req_paddr_card = pc;
        req_pid = pid; req_n_pages = n; req_unmap = unmap; req_valid = 1'b1;
        check_bit({name, "_req_ready"}, req_ready, 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0;
        req_vaddr = ~va; req_paddr_host = ~ph; req_paddr_card = ~pc;
        req_pid = ~pid; req_n_pages = 16'hFFFF; req_unmap = ~unmap;
    endtask

    // Drives tready (always 1, or the 1,0,0,1 pattern) and checks every beat.
    task automatic collect(input string name, input int n, input logic stall,
                           input logic [127:0] exp_first, input logic [127:0] exp_last);
        logic [0:3]   pat = 4'b1001;
        logic [127:0] prev = '0;
        logic         prev_stall = 1'b0;
        int           got = 0;
        int           cyc = 0;
        while (got < n && cyc < 64) begin
            m_if.tready = stall ? pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                check_bit($sformatf("%s_stall_valid%0d", name, cyc), m_if.tvalid, 1'b1);
                check($sformatf("%s_stall_hold%0d", name, cyc), m_if.tdata, prev);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (got == 0)
                    check({name, "_first"}, m_if.tdata, exp_first);
                if (got == n - 1)
                    check({name, "_last"}, m_if.tdata, exp_last);
                check_bit($sformatf("%s_tlast%0d", name, got), m_if.tlast, got == n - 1);
                got++;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev = m_if.tdata;
            @(negedge aclk);
            cyc++;
        end
        m_if.tready = 1'b0;
        check({name, "_beats"}, 128'(got), 128'(n));
        check_bit({name, "_tvalid_after"}, m_if.tvalid, 1'b0);
        exp_beats += n;
        check({name, "_beat_cnt"}, 128'(beat_cnt), 128'(exp_beats));
    endtask

    // Called at the first falling edge in the wait state (k=0). Pulses
    // done_map at k=done_delay (none if negative) and checks the completion.
    task automatic wait_cpl(input string name, input int done_delay,
                            input logic exp_err, input int exp_k);
        int   first_k = -1;
        int   cnt = 0;
        logic err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cpl_valid) begin
                if (cnt == 0) begin
                    first_k = k;
                    err = cpl_err;
                    check_bit({name, "_ready_in_cpl"}, req_ready, 1'b0);
                end
                cnt++;
            end
            if (first_k >= 0 && k == first_k + 1)
                check_bit({name, "_ready_after_cpl"}, req_ready, 1'b1);
            done_map = (k == done_delay);
            @(negedge aclk);
        end
        done_map = 1'b0;
        check({name, "_cpl_count"}, 128'(cnt), 128'd1);
        check({name, "_cpl_cycle"}, 128'(first_k), 128'(exp_k));
        check_bit({name, "_cpl_err"}, err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Map of 3 pages: vpn 0x12345 -> index 0x345, tag 0x48, pid 5, valid.
        vecs[0] = '{48'h0000_1234_5000, 44'h000_ABCD_E000, 44'h000_1111_1000, 6'd5, 16'd3,
                    1'b0, 1'b0, 2,
                    128'h0001_1111_000A_BCDE_0000_0450_0001_2345,
                    128'h0001_1113_000A_BCE0_0000_0450_0001_2347};
        // Removal of one page: no physical fields, valid bit clear.
        vecs[1] = '{48'h0000_007F_F000, 44'h123_4567_8000, 44'h0AB_CDEF_0000, 6'd3, 16'd1,
                    1'b1, 1'b0, 5,
                    128'h0000_0000_0000_0000_0000_0030_0000_07FF,
                    128'h0000_0000_0000_0000_0000_0030_0000_07FF};
        // vpn and ppn_h wrap to zero on the second beat.
        vecs[2] = '{48'hFFFF_FFFF_F000, 44'hFFF_FFFF_F000, 44'h000_0000_1000, 6'h3F, 16'd2,
                    1'b0, 1'b0, 0,
                    128'h0000_0001_FFFF_FFFF_0000_07FF_FFFF_FFFF,
                    128'h0000_0002_0000_0000_0000_07F0_0000_0000};
        // First request again under a 1,0,0,1 tready pattern.
        vecs[3] = '{48'h0000_1234_5000, 44'h000_ABCD_E000, 44'h000_1111_1000, 6'd5, 16'd3,
                    1'b0, 1'b1, 3,
                    128'h0001_1111_000A_BCDE_0000_0450_0001_2345,
                    128'h0001_1113_000A_BCE0_0000_0450_0001_2347};

        areset = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_paddr_host = '0;
        req_paddr_card = '0; req_pid = '0; req_n_pages = '0; req_unmap = 1'b0;
        done_map = 1'b0; m_if.tready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_bit("rst_req_ready", req_ready, 1'b1);
        check_bit("rst_tvalid", m_if.tvalid, 1'b0);
        check_bit("rst_tlast", m_if.tlast, 1'b0);
        check("rst_tdata", m_if.tdata, '0);
        check_bit("rst_cpl_valid", cpl_valid, 1'b0);
        check_bit("rst_cpl_err", cpl_err, 1'b0);
        check("rst_beat_cnt", 128'(beat_cnt), '0);
        areset = 1'b0;
        @(negedge aclk);

        for (int i = 0; i < 4; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send_req(nm, vecs[i].vaddr, vecs[i].ph, vecs[i].pc, vecs[i].pid,
                     vecs[i].n, vecs[i].unmap);
            collect(nm, int'(vecs[i].n), vecs[i].stall, vecs[i].exp_first, vecs[i].exp_last);
            wait_cpl(nm, vecs[i].done_delay, 1'b0, vecs[i].done_delay + 1);
        end

        // Zero pages: completion in the cycle after the acceptance edge, no beats.
        send_req("zero", 48'h0000_0000_1000, '0, '0, 6'd1, 16'd0, 1'b0);
        check_bit("zero_cpl_valid", cpl_valid, 1'b1);
        check_bit("zero_cpl_err", cpl_err, 1'b0);
        check_bit("zero_tvalid", m_if.tvalid, 1'b0);
        check_bit("zero_ready_in_cpl", req_ready, 1'b0);
        @(negedge aclk);
        check_bit("zero_cpl_drop", cpl_valid, 1'b0);
        check_bit("zero_ready_after", req_ready, 1'b1);

        // done_map while idle has no effect.
        done_map = 1'b1;
        @(negedge aclk);
        done_map = 1'b0;
        check_bit("idle_done_cpl", cpl_valid, 1'b0);
        check_bit("idle_done_ready", req_ready, 1'b1);
        @(negedge aclk);
        check_bit("idle_done_cpl2", cpl_valid, 1'b0);

        // Timeout: completion with error 16 cycles after entering the wait state.
        send_req("tmo", vecs[1].vaddr, vecs[1].ph, vecs[1].pc, vecs[1].pid, 16'd1, 1'b1);
        collect("tmo", 1, 1'b0, vecs[1].exp_first, vecs[1].exp_last);
        wait_cpl("tmo", -1, 1'b1, 16);

        // done_map on the expiry cycle wins over the timeout.
        send_req("tmo_race", vecs[1].vaddr, vecs[1].ph, vecs[1].pc, vecs[1].pid, 16'd1, 1'b1);
        collect("tmo_race", 1, 1'b0, vecs[1].exp_first, vecs[1].exp_last);
        wait_cpl("tmo_race", 15, 1'b0, 16);

        // Reset after the first of four beats aborts silently.
        send_req("abort", vecs[0].vaddr, vecs[0].ph, vecs[0].pc, vecs[0].pid, 16'd4, 1'b0);
        m_if.tready = 1'b1;
        check("abort_first", m_if.tdata, vecs[0].exp_first);
        @(negedge aclk);
        check("abort_beat_cnt_pre", 128'(beat_cnt), 128'(exp_beats + 1));
        check_bit("abort_tvalid_pre", m_if.tvalid, 1'b1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        exp_beats = 0;
        check_bit("abort_tvalid", m_if.tvalid, 1'b0);
        check("abort_beat_cnt", 128'(beat_cnt), 128'(exp_beats));
        check_bit("abort_req_ready", req_ready, 1'b1);
        check("abort_tdata", m_if.tdata, '0);
        begin
            int n_cpl = 0;
            int n_valid = 0;
            for (int k = 0; k < 20; k++) begin
                if (cpl_valid) n_cpl++;
                if (m_if.tvalid) n_valid++;
                done_map = (k == 3);
                @(negedge aclk);
            end
            done_map = 1'b0;
            check("abort_no_cpl", 128'(n_cpl), 128'd0);
            check("abort_no_beats", 128'(n_valid), 128'd0);
        end
        m_if.tready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
